// File: rtl/sp_ram_bytewr_if.sv
// ----------------------------------------------------------------------------
// sp_ram_bytewr_if
//
// Purpose:
//   Bundles the access bus of the byte-writable single-port RAM so that the
//   requester and the memory share one typed connection.
//
// Signals:
//   clr        requester -> RAM  request a full re-clear of the array
//   wr_en      requester -> RAM  write request
//   rd_en      requester -> RAM  read request
//   be         requester -> RAM  byte enables, be[i] gates din byte i
//   add        requester -> RAM  word address
//   din        requester -> RAM  write data
//   dout       RAM -> requester  registered read data
//   dout_valid RAM -> requester  one-cycle pulse, dout updated by a read
//   busy       RAM -> requester  clear engine running, accesses ignored
//   err        RAM -> requester  one-cycle pulse, access address out of range
//
// Modports:
//   master  the requester side
//   slave   the RAM side
// ----------------------------------------------------------------------------
interface sp_ram_bytewr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);

    logic                  clr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     add;
    logic [DATA_W-1:0]     din;
    logic [DATA_W-1:0]     dout;
    logic                  dout_valid;
    logic                  busy;
    logic                  err;

    modport master (
        output clr,
        output wr_en,
        output rd_en,
        output be,
        output add,
        output din,
        input  dout,
        input  dout_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  clr,
        input  wr_en,
        input  rd_en,
        input  be,
        input  add,
        input  din,
        output dout,
        output dout_valid,
        output busy,
        output err
    );

endinterface

// File: rtl/sp_ram_bytewr.sv
// ----------------------------------------------------------------------------
// sp_ram_bytewr
//
// Purpose:
//   Parametrised single-port synchronous RAM with per-byte write enables,
//   selectable read-during-write behaviour and a sequential clear engine.
//   The array itself has no reset; instead a small FSM walks every address
//   once after reset (or on request) and writes CLR_VAL, one word per cycle,
//   so the storage stays inferable as block RAM.
//
// Parameters:
//   DATA_W   word width in bits, a multiple of 8
//   ADDR_W   address width
//   DEPTH    number of words, 2 <= DEPTH <= 2**ADDR_W
//   WR_MODE  same-cycle read/write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
//   CLR_VAL  value written into every word by the clear engine
//
// Ports:
//   clk      clock, everything on the rising edge
//   rst_n    asynchronous active-low reset
//   bus_io   access bus (slave side of sp_ram_bytewr_if)
// ----------------------------------------------------------------------------
module sp_ram_bytewr #(
    parameter int                 DATA_W  = 8,
    parameter int                 ADDR_W  = 6,
    parameter int                 DEPTH   = 64,
    parameter int                 WR_MODE = 0,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sp_ram_bytewr_if.slave        bus_io
);

    localparam int NBYTES = DATA_W / 8;

    // Last address visited by the clear engine and the range limit, both
    // sized so comparisons against the address bus are width-exact.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   ram [DEPTH];

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;

    logic [DATA_W-1:0]   dout_q;
    logic [DATA_W-1:0]   dout_d;
    logic                dout_valid_q;
    logic                err_q;

    // Single memory write port, shared between clear engine and user writes
    logic                memWe;
    logic [NBYTES-1:0]   memBe;
    logic [ADDR_W-1:0]   memAddr;
    logic [DATA_W-1:0]   memWdata;

    logic                inRange;
    logic                rdFire;
    logic                errFire;
    logic                busyComb;
    logic [ADDR_W-1:0]   rdIdx;
    logic [DATA_W-1:0]   oldWord;
    logic [DATA_W-1:0]   mergedWord;
    logic [DATA_W-1:0]   readWord;

    // ------------------------------------------------------------------
    // Address decode and read data path
    // ------------------------------------------------------------------

    // The comparison is one bit wider than the address so DEPTH equal to
    // 2**ADDR_W needs no special case.
    assign inRange = ({1'b0, bus_io.add} < DEPTH_L);

    // Out-of-range reads are never committed, but the array index is still
    // steered to a legal word so simulation never indexes past the array.
    assign rdIdx   = inRange ? bus_io.add : '0;
    assign oldWord = ram[rdIdx];

    // Word as it will look after this cycle's write: new bytes where the
    // write enables them, stored bytes everywhere else. With no write in
    // the same cycle this is simply the stored word.
    always_comb begin
        mergedWord = oldWord;
        for (int i = 0; i < NBYTES; i++) begin
            if (bus_io.wr_en && bus_io.be[i]) begin
                mergedWord[8*i +: 8] = bus_io.din[8*i +: 8];
            end
        end
    end

    // READ_FIRST and NO_CHANGE both return the stored word when a read is
    // allowed to complete; NO_CHANGE differs only by suppressing the read,
    // which is handled in the output decode below.
    assign readWord = (WR_MODE == 1) ? mergedWord : oldWord;

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------

    // Reset parks the engine at address 0 in CLEAR so that the array is
    // rebuilt word by word once rst_n is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------

    // CLEAR walks cnt from 0 to DEPTH-1 and then returns to IDLE with cnt
    // back at 0. In IDLE, clr restarts the walk and wins over any access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (bus_io.clr) begin
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: output / datapath control decode
    // ------------------------------------------------------------------

    // In CLEAR the write port is owned by the clear engine and every user
    // request is ignored. In IDLE a clr request drops the access entirely.
    // Out-of-range accesses raise err and touch neither memory nor dout.
    always_comb begin
        busyComb = 1'b0;
        memWe    = 1'b0;
        memBe    = '0;
        memAddr  = cnt_q;
        memWdata = CLR_VAL;
        rdFire   = 1'b0;
        errFire  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                busyComb = 1'b1;
                memWe    = 1'b1;
                memBe    = '1;
                memAddr  = cnt_q;
                memWdata = CLR_VAL;
            end
            IDLE: begin
                if (!bus_io.clr) begin
                    memWe    = bus_io.wr_en && inRange;
                    memBe    = bus_io.be;
                    memAddr  = bus_io.add;
                    memWdata = bus_io.din;
                    // NO_CHANGE suppresses a read that coincides with a write
                    rdFire   = bus_io.rd_en && inRange &&
                               !((WR_MODE == 2) && bus_io.wr_en);
                    errFire  = (bus_io.wr_en || bus_io.rd_en) && !inRange;
                end
            end
            default: begin
                busyComb = 1'b1;
            end
        endcase
    end

    // dout only moves when a read completes; otherwise it holds.
    assign dout_d = rdFire ? readWord : dout_q;

    // ------------------------------------------------------------------
    // Memory array write port
    // ------------------------------------------------------------------

    // No reset on the array: it is initialised by the clear engine, which
    // keeps this block mappable onto block RAM with byte-write enables.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (memBe[i]) begin
                    ram[memAddr][8*i +: 8] <= memWdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------

    // dout_valid and err are single-cycle pulses; they can never coincide
    // because a read only fires for in-range addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= rdFire;
            err_q        <= errFire;
        end
    end

    assign bus_io.dout       = dout_q;
    assign bus_io.dout_valid = dout_valid_q;
    assign bus_io.err        = err_q;
    assign bus_io.busy       = busyComb;

endmodule

// File: tb/tb_sp_ram_bytewr.sv
// ----------------------------------------------------------------------------
// tb_sp_ram_bytewr
//
// Purpose:
//   Directed self-checking bench for sp_ram_bytewr. Three instances share
//   clock and reset:
//     unit 0 (A): 8-bit x 64,  READ_FIRST,  CLR_VAL 0x00
//     unit 1 (B): 32-bit x 48, WRITE_FIRST, CLR_VAL 0x00, ADDR_W 6
//     unit 2 (C): 8-bit x 16,  NO_CHANGE,   CLR_VAL 0x5A, ADDR_W 4
//   Inputs change 1 time unit after a rising edge and outputs are sampled
//   at the same point, so every sample reflects the edge just taken.
// ----------------------------------------------------------------------------
module tb_sp_ram_bytewr;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    sp_ram_bytewr_if #(.DATA_W(8),  .ADDR_W(6)) ifA ();
    sp_ram_bytewr_if #(.DATA_W(32), .ADDR_W(6)) ifB ();
    sp_ram_bytewr_if #(.DATA_W(8),  .ADDR_W(4)) ifC ();

    sp_ram_bytewr #(
        .DATA_W(8), .ADDR_W(6), .DEPTH(64), .WR_MODE(0), .CLR_VAL(8'h00)
    ) uA (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (ifA.slave)
    );

    sp_ram_bytewr #(
        .DATA_W(32), .ADDR_W(6), .DEPTH(48), .WR_MODE(1), .CLR_VAL(32'h0)
    ) uB (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (ifB.slave)
    );

    sp_ram_bytewr #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(16), .WR_MODE(2), .CLR_VAL(8'h5A)
    ) uC (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (ifC.slave)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observation helpers, all zero-extended to 32 bits
    function automatic logic [31:0] doutOf(input int u);
        case (u)
            0:       return {24'h0, ifA.dout};
            1:       return ifB.dout;
            default: return {24'h0, ifC.dout};
        endcase
    endfunction

    function automatic logic [31:0] validOf(input int u);
        case (u)
            0:       return {31'h0, ifA.dout_valid};
            1:       return {31'h0, ifB.dout_valid};
            default: return {31'h0, ifC.dout_valid};
        endcase
    endfunction

    function automatic logic [31:0] errOf(input int u);
        case (u)
            0:       return {31'h0, ifA.err};
            1:       return {31'h0, ifB.err};
            default: return {31'h0, ifC.err};
        endcase
    endfunction

    function automatic logic [31:0] busyOf(input int u);
        case (u)
            0:       return {31'h0, ifA.busy};
            1:       return {31'h0, ifB.busy};
            default: return {31'h0, ifC.busy};
        endcase
    endfunction

    task automatic idleAll();
        ifA.clr = 1'b0; ifA.wr_en = 1'b0; ifA.rd_en = 1'b0;
        ifA.be = '0; ifA.add = '0; ifA.din = '0;
        ifB.clr = 1'b0; ifB.wr_en = 1'b0; ifB.rd_en = 1'b0;
        ifB.be = '0; ifB.add = '0; ifB.din = '0;
        ifC.clr = 1'b0; ifC.wr_en = 1'b0; ifC.rd_en = 1'b0;
        ifC.be = '0; ifC.add = '0; ifC.din = '0;
    endtask

    // Drive one request on unit u for exactly one rising edge, then return
    // 1 time unit after that edge with all requests idle again.
    task automatic applyStimulus(input int u, input logic wr, input logic rd,
                                 input logic cl, input logic [3:0] be,
                                 input logic [5:0] ad, input logic [31:0] dn);
        case (u)
            0: begin
                ifA.wr_en = wr; ifA.rd_en = rd; ifA.clr = cl;
                ifA.be = be[0]; ifA.add = ad; ifA.din = dn[7:0];
            end
            1: begin
                ifB.wr_en = wr; ifB.rd_en = rd; ifB.clr = cl;
                ifB.be = be; ifB.add = ad; ifB.din = dn;
            end
            default: begin
                ifC.wr_en = wr; ifC.rd_en = rd; ifC.clr = cl;
                ifC.be = be[0]; ifC.add = ad[3:0]; ifC.din = dn[7:0];
            end
        endcase
        @(posedge clk);
        #1;
        idleAll();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idleAll();

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busyA",  busyOf(0),  32'd1);
        checkOutput("rst_doutA",  doutOf(0),  32'd0);
        checkOutput("rst_validA", validOf(0), 32'd0);
        checkOutput("rst_errA",   errOf(0),   32'd0);
        checkOutput("rst_busyB",  busyOf(1),  32'd1);
        checkOutput("rst_doutB",  doutOf(1),  32'd0);

        // ---------------- initial clear sequence ----------------
        // Unit A gets a write+read to address 2 held across edges 1..9;
        // it must be ignored while busy.
        rst_n = 1'b1;
        ifA.wr_en = 1'b1; ifA.rd_en = 1'b1; ifA.be = 1'b1;
        ifA.add = 6'd2; ifA.din = 8'h77;
        for (int e = 1; e <= 64; e++) begin
            @(posedge clk);
            #1;
            if (e == 7) begin
                checkOutput("busyAccValidA", validOf(0), 32'd0);
                checkOutput("busyAccErrA",   errOf(0),   32'd0);
            end
            if (e == 9) idleAll();
            if (e == 15) checkOutput("clrC_e15", busyOf(2), 32'd1);
            if (e == 16) checkOutput("clrC_e16", busyOf(2), 32'd0);
            if (e == 47) checkOutput("clrB_e47", busyOf(1), 32'd1);
            if (e == 48) checkOutput("clrB_e48", busyOf(1), 32'd0);
            if (e == 63) checkOutput("clrA_e63", busyOf(0), 32'd1);
            if (e == 64) checkOutput("clrA_e64", busyOf(0), 32'd0);
        end

        // ---------------- reads after clear (unit A) ----------------
        applyStimulus(0, 0, 1, 0, 4'h0, 6'd0, 32'h0);
        checkOutput("rd0_dout",  doutOf(0),  32'h00);
        checkOutput("rd0_valid", validOf(0), 32'd1);
        applyStimulus(0, 0, 0, 0, 4'h0, 6'd0, 32'h0);
        checkOutput("rd0_pulseEnd", validOf(0), 32'd0);
        applyStimulus(0, 0, 1, 0, 4'h0, 6'd31, 32'h0);
        checkOutput("rd31_dout",  doutOf(0),  32'h00);
        checkOutput("rd31_valid", validOf(0), 32'd1);
        applyStimulus(0, 0, 1, 0, 4'h0, 6'd63, 32'h0);
        checkOutput("rd63_dout",  doutOf(0),  32'h00);
        checkOutput("rd63_valid", validOf(0), 32'd1);
        applyStimulus(0, 0, 1, 0, 4'h0, 6'd2, 32'h0);
        checkOutput("busyWrDropped", doutOf(0), 32'h00);

        // ---------------- READ_FIRST read-during-write (unit A) ----------
        applyStimulus(0, 1, 0, 0, 4'h1, 6'd3, 32'h55);
        applyStimulus(0, 1, 1, 0, 4'h1, 6'd3, 32'hA5);
        checkOutput("rfRdw_dout",  doutOf(0),  32'h55);
        checkOutput("rfRdw_valid", validOf(0), 32'd1);
        applyStimulus(0, 0, 1, 0, 4'h0, 6'd3, 32'h0);
        checkOutput("rfAfter_dout", doutOf(0), 32'hA5);

        // ---------------- byte enables (unit B, 32 bit) ----------------
        applyStimulus(1, 1, 0, 0, 4'hF, 6'd5, 32'h11223344);
        checkOutput("beWr_validB", validOf(1), 32'd0);
        applyStimulus(1, 1, 0, 0, 4'b0101, 6'd5, 32'hAABBCCDD);
        applyStimulus(1, 0, 1, 0, 4'h0, 6'd5, 32'h0);
        checkOutput("beRd_dout",  doutOf(1),  32'h11BB33DD);
        checkOutput("beRd_valid", validOf(1), 32'd1);
        applyStimulus(1, 1, 0, 0, 4'h0, 6'd5, 32'hFFFFFFFF);
        applyStimulus(1, 0, 1, 0, 4'h0, 6'd5, 32'h0);
        checkOutput("beZeroNoop", doutOf(1), 32'h11BB33DD);

        // ---------------- WRITE_FIRST read-during-write (unit B) --------
        applyStimulus(1, 1, 0, 0, 4'hF, 6'd3, 32'h55);
        applyStimulus(1, 1, 1, 0, 4'hF, 6'd3, 32'hA5);
        checkOutput("wfRdw_dout",  doutOf(1),  32'hA5);
        checkOutput("wfRdw_valid", validOf(1), 32'd1);
        applyStimulus(1, 0, 1, 0, 4'h0, 6'd3, 32'h0);
        checkOutput("wfAfter_dout", doutOf(1), 32'hA5);
        applyStimulus(1, 1, 0, 0, 4'hF, 6'd7, 32'h11223344);
        applyStimulus(1, 1, 1, 0, 4'b0101, 6'd7, 32'hAABBCCDD);
        checkOutput("wfMerge_dout", doutOf(1), 32'h11BB33DD);

        // ---------------- out of range (unit B, DEPTH 48) ----------------
        applyStimulus(1, 1, 0, 0, 4'hF, 6'd50, 32'hCAFEF00D);
        checkOutput("oorWr_err",   errOf(1),   32'd1);
        checkOutput("oorWr_valid", validOf(1), 32'd0);
        applyStimulus(1, 0, 0, 0, 4'h0, 6'd0, 32'h0);
        checkOutput("oorErrPulseEnd", errOf(1), 32'd0);
        applyStimulus(1, 0, 1, 0, 4'h0, 6'd50, 32'h0);
        checkOutput("oorRd_err",   errOf(1),   32'd1);
        checkOutput("oorRd_valid", validOf(1), 32'd0);
        checkOutput("oorRd_hold",  doutOf(1),  32'h11BB33DD);
        applyStimulus(1, 0, 1, 0, 4'h0, 6'd2, 32'h0);
        checkOutput("oorNoAlias2", doutOf(1), 32'h0);
        applyStimulus(1, 0, 1, 0, 4'h0, 6'd18, 32'h0);
        checkOutput("oorNoAlias18", doutOf(1), 32'h0);

        // ---------------- NO_CHANGE and CLR_VAL (unit C) ----------------
        applyStimulus(2, 0, 1, 0, 4'h0, 6'd9, 32'h0);
        checkOutput("clrValC", doutOf(2), 32'h5A);
        applyStimulus(2, 1, 0, 0, 4'h1, 6'd3, 32'h55);
        applyStimulus(2, 1, 1, 0, 4'h1, 6'd3, 32'hA5);
        checkOutput("ncRdw_hold",  doutOf(2),  32'h5A);
        checkOutput("ncRdw_valid", validOf(2), 32'd0);
        applyStimulus(2, 0, 1, 0, 4'h0, 6'd3, 32'h0);
        checkOutput("ncAfter_dout", doutOf(2), 32'hA5);

        // ---------------- clr priority (unit A) ----------------
        for (int a = 0; a < 64; a++) begin
            applyStimulus(0, 1, 0, 0, 4'h1, 6'(a), 32'hFF);
        end
        applyStimulus(0, 0, 1, 0, 4'h0, 6'd40, 32'h0);
        checkOutput("fillCheck", doutOf(0), 32'hFF);
        applyStimulus(0, 1, 0, 1, 4'h1, 6'd0, 32'h12);
        checkOutput("clrReq_busy", busyOf(0), 32'd1);
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (k == 63) checkOutput("clrReq_k63", busyOf(0), 32'd1);
            if (k == 64) checkOutput("clrReq_k64", busyOf(0), 32'd0);
        end
        for (int a = 0; a < 64; a++) begin
            applyStimulus(0, 0, 1, 0, 4'h0, 6'(a), 32'h0);
            checkOutput($sformatf("clrRd%0d", a), doutOf(0), 32'h00);
        end

        // ---------------- reset mid-clear (unit A) ----------------
        applyStimulus(0, 1, 0, 0, 4'h1, 6'd10, 32'h3C);
        applyStimulus(0, 0, 1, 0, 4'h0, 6'd10, 32'h0);
        checkOutput("preRst_dout", doutOf(0), 32'h3C);
        applyStimulus(0, 0, 0, 1, 4'h0, 6'd0, 32'h0);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midRst_dout",  doutOf(0),  32'h00);
        checkOutput("midRst_busy",  busyOf(0),  32'd1);
        checkOutput("midRst_doutB", doutOf(1),  32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 64; e++) begin
            @(posedge clk);
            #1;
            if (e == 63) checkOutput("reclr_e63", busyOf(0), 32'd1);
            if (e == 64) checkOutput("reclr_e64", busyOf(0), 32'd0);
        end
        applyStimulus(0, 0, 1, 0, 4'h0, 6'd10, 32'h0);
        checkOutput("reclr_rd10",    doutOf(0),  32'h00);
        checkOutput("reclr_rdValid", validOf(0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
